// File: rtl/byte_lane_dly_pkg.sv
// Shared delay-map constants, FSM state type and address helpers
// for the byte-lane delay loader.
package byte_lane_dly_pkg;

    localparam logic [4:0] DLY_ODQ_FIRST = 5'd0;
    localparam logic [4:0] DLY_ODM       = 5'd9;
    localparam logic [4:0] DLY_IDQ_FIRST = 5'd16;
    localparam logic [4:0] DLY_IDQS      = 5'd24;
    localparam int         DLY_NUM       = 19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_SET
    } dly_state_e;

    function automatic logic dly_addr_valid(input logic [4:0] a);
        return (a <= DLY_ODM) ||
               ((a >= DLY_IDQ_FIRST) && (a <= DLY_IDQS));
    endfunction

    function automatic logic [4:0] dly_addr_next(input logic [4:0] a);
        return (a == DLY_ODM) ? DLY_IDQ_FIRST : a + 5'd1;
    endfunction

    // Dense shadow index: 0..9 map straight, 16..24 fold onto 10..18.
    function automatic logic [4:0] dly_addr_idx(input logic [4:0] a);
        return (a <= DLY_ODM) ? a : a - 5'd6;
    endfunction

endpackage

// File: rtl/byte_lane_dly_loader_shadow.sv
// 19-entry shadow of the lane delay taps with write decode, load read port
// and optional registered readback (BYTE_LANE_DLY_READBACK_EN).
module byte_lane_dly_shadow
    import byte_lane_dly_pkg::*;
#(
    parameter logic [7:0] DLY_INIT = 8'h00
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] ld_addr,
    output logic [7:0] ld_data
`ifdef BYTE_LANE_DLY_READBACK_EN
    ,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
`endif
);

    logic [7:0] mem_q [DLY_NUM];
    logic [7:0] mem_d [DLY_NUM];

    always_comb begin
        mem_d = mem_q;
        if (wr_en && dly_addr_valid(wr_addr))
            mem_d[dly_addr_idx(wr_addr)] = wr_data;
    end

    always_comb begin
        ld_data = 8'h00;
        if (dly_addr_valid(ld_addr))
            ld_data = mem_q[dly_addr_idx(ld_addr)];
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY_NUM; i++)
                mem_q[i] <= DLY_INIT;
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef BYTE_LANE_DLY_READBACK_EN
    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    always_comb begin
        rd_data_d = 8'h00;
        if (dly_addr_valid(rd_addr))
            rd_data_d = mem_q[dly_addr_idx(rd_addr)];
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= 8'h00;
        else
            rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/byte_lane_dly_loader.sv
// Delay-programming master for one DDR3 byte lane: load shadow taps, then set.
// Optional readback port enabled by BYTE_LANE_DLY_READBACK_EN.
module byte_lane_dly_loader
    import byte_lane_dly_pkg::*;
#(
    parameter logic [7:0] DLY_INIT = 8'h00
) (
    input  logic       clk_div,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       start_one,
    input  logic [4:0] one_addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] dly_data,
    output logic [4:0] dly_addr,
    output logic       ld_delay,
    output logic       set
`ifdef BYTE_LANE_DLY_READBACK_EN
    ,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
`endif
);

    dly_state_e state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       single_q, single_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ld_delay_q, ld_delay_d;
    logic       set_q, set_d;
    logic [4:0] dly_addr_q, dly_addr_d;
    logic [7:0] dly_data_q, dly_data_d;
    logic [7:0] ld_data;

    byte_lane_dly_shadow #(
        .DLY_INIT (DLY_INIT)
    ) u_shadow (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ld_addr (cnt_q),
        .ld_data (ld_data)
`ifdef BYTE_LANE_DLY_READBACK_EN
        ,
        .rd_addr (rd_addr),
        .rd_data (rd_data)
`endif
    );

    // Outputs are registered from the current state, so they trail it by one edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        single_d   = single_q;
        busy_d     = (state_q != ST_IDLE);
        done_d     = set_q;
        ld_delay_d = 1'b0;
        set_d      = 1'b0;
        dly_addr_d = dly_addr_q;
        dly_data_d = dly_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    cnt_d    = DLY_ODQ_FIRST;
                    single_d = 1'b0;
                end else if (start_one && dly_addr_valid(one_addr)) begin
                    state_d  = ST_LOAD;
                    cnt_d    = one_addr;
                    single_d = 1'b1;
                end
            end
            ST_LOAD: begin
                ld_delay_d = 1'b1;
                dly_addr_d = cnt_q;
                dly_data_d = ld_data;
                if (single_q || (cnt_q == DLY_IDQS))
                    state_d = ST_GAP;
                else
                    cnt_d = dly_addr_next(cnt_q);
            end
            ST_GAP: state_d = ST_SET;
            ST_SET: begin
                set_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= DLY_ODQ_FIRST;
            single_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ld_delay_q <= 1'b0;
            set_q      <= 1'b0;
            dly_addr_q <= 5'd0;
            dly_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            single_q   <= single_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ld_delay_q <= ld_delay_d;
            set_q      <= set_d;
            dly_addr_q <= dly_addr_d;
            dly_data_q <= dly_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ld_delay = ld_delay_q;
    assign set      = set_q;
    assign dly_addr = dly_addr_q;
    assign dly_data = dly_data_q;

endmodule

// File: tb/tb_byte_lane_dly_loader.sv
// Scoreboard bench for byte_lane_dly_loader: expected (addr,data) pairs are
// queued per sequence and matched against every ld_delay beat.
module tb_byte_lane_dly_loader;

    logic       clk_div = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       start_one;
    logic [4:0] one_addr;
    logic       busy;
    logic       done;
    logic [7:0] dly_data;
    logic [4:0] dly_addr;
    logic       ld_delay;
    logic       set;

    int n_pass  = 0;
    int n_total = 0;
    bit sb_en   = 1'b1;

    logic [7:0]  model [32];
    logic [12:0] exp_q [$];

    always #5 clk_div = ~clk_div;

    byte_lane_dly_loader #(
        .DLY_INIT (8'h00)
    ) dut (
        .clk_div   (clk_div),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .start_one (start_one),
        .one_addr  (one_addr),
        .busy      (busy),
        .done      (done),
        .dly_data  (dly_data),
        .dly_addr  (dly_addr),
        .ld_delay  (ld_delay),
        .set       (set)
    );

    function automatic bit is_valid(input int a);
        return (a <= 9) || (a >= 16 && a <= 24);
    endfunction

    always @(negedge clk_div) begin
        if (sb_en && rst_n && ld_delay) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra: got addr=%0d data=%02h, required no load",
                         dly_addr, dly_data);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                if ({dly_addr, dly_data} !== e)
                    $display("FAIL sb_load: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             dly_addr, dly_data, e[12:8], e[7:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic push_full();
        for (int a = 0; a < 25; a++)
            if (is_valid(a))
                exp_q.push_back({a[4:0], model[a]});
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk_div);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk_div);
        wr_en   = 1'b0;
        if (is_valid(a))
            model[a] = d;
    endtask

    task automatic run_seq(input bit single, input logic [4:0] oa,
                           input int wk0, input logic [4:0] wa0, input logic [7:0] wd0,
                           input int wk1, input logic [4:0] wa1, input logic [7:0] wd1,
                           input int sk);
        int nld;
        nld = single ? 1 : 19;
        @(negedge clk_div);
        if (single) begin
            start_one = 1'b1;
            one_addr  = oa;
        end else begin
            start = 1'b1;
        end
        @(negedge clk_div);
        start     = 1'b0;
        start_one = 1'b0;
        for (int k = 1; k <= nld + 3; k++) begin
            @(negedge clk_div);
            n_total += 4;
            if (ld_delay !== (k <= nld))
                $display("FAIL ld_delay@N+%0d: got %b, required %b", k, ld_delay, k <= nld);
            else n_pass++;
            if (set !== (k == nld + 2))
                $display("FAIL set@N+%0d: got %b, required %b", k, set, k == nld + 2);
            else n_pass++;
            if (done !== (k == nld + 3))
                $display("FAIL done@N+%0d: got %b, required %b", k, done, k == nld + 3);
            else n_pass++;
            if (busy !== (k <= nld + 2))
                $display("FAIL busy@N+%0d: got %b, required %b", k, busy, k <= nld + 2);
            else n_pass++;
            wr_en   = (k == wk0) || (k == wk1);
            wr_addr = (k == wk1) ? wa1 : wa0;
            wr_data = (k == wk1) ? wd1 : wd0;
            start   = (k == sk);
        end
        @(negedge clk_div);
        wr_en = 1'b0;
        start = 1'b0;
        n_total += 2;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL seq_end: got done=%b busy=%b, required 0 0", done, busy);
        else n_pass++;
        if (exp_q.size() != 0)
            $display("FAIL sb_left: got %0d unsent loads, required 0", exp_q.size());
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic check_zero_outs(input string tag);
        n_total++;
        if ({busy, done, ld_delay, set, dly_addr, dly_data} !== 17'd0)
            $display("FAIL %s: got busy=%b done=%b ld=%b set=%b addr=%0d data=%02h, required all 0",
                     tag, busy, done, ld_delay, set, dly_addr, dly_data);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_one = 1'b0; one_addr = '0;
        for (int a = 0; a < 32; a++) model[a] = 8'h00;
        #12;
        check_zero_outs("reset_state");
        @(negedge clk_div);
        rst_n = 1'b1;
    endtask

    task automatic test_full_init();
        push_full();
        run_seq(1'b0, 5'd0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
    endtask

    task automatic test_full_pattern();
        for (int a = 0; a < 25; a++)
            if (is_valid(a))
                wr(a[4:0], a[7:0] + 8'h40);
        push_full();
        run_seq(1'b0, 5'd0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
    endtask

    task automatic test_invalid();
        wr(5'd10, 8'hFF);
        wr(5'd31, 8'hFF);
        push_full();
        run_seq(1'b0, 5'd0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
        @(negedge clk_div);
        start_one = 1'b1;
        one_addr  = 5'd12;
        @(negedge clk_div);
        start_one = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_div);
            n_total++;
            if (busy !== 1'b0 || done !== 1'b0 || ld_delay !== 1'b0)
                $display("FAIL bad_one@%0d: got busy=%b done=%b ld=%b, required 0 0 0",
                         k, busy, done, ld_delay);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        wr(5'd24, 8'h5A);
        exp_q.push_back({5'd24, 8'h5A});
        run_seq(1'b1, 5'd24, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, 1);
    endtask

    task automatic test_collision();
        model[20] = 8'h11;
        push_full();
        model[5] = 8'h22;
        run_seq(1'b0, 5'd0, 12, 5'd20, 8'h11, 5, 5'd5, 8'h22, -1);
        exp_q.push_back({5'd5, 8'h22});
        run_seq(1'b1, 5'd5, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
    endtask

    task automatic test_mid_reset();
        sb_en = 1'b0;
        @(negedge clk_div);
        start = 1'b1;
        @(posedge clk_div);
        #1 start = 1'b0;
        repeat (10) @(posedge clk_div);
        #2;
        n_total++;
        if (ld_delay !== 1'b1 || busy !== 1'b1)
            $display("FAIL pre_reset: got ld=%b busy=%b, required 1 1", ld_delay, busy);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        check_zero_outs("async_reset");
        @(negedge clk_div);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_div);
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("FAIL post_reset@%0d: got done=%b busy=%b, required 0 0", k, done, busy);
            else n_pass++;
        end
        sb_en = 1'b1;
        for (int a = 0; a < 32; a++) model[a] = 8'h00;
        push_full();
        run_seq(1'b0, 5'd0, -1, 5'd0, 8'h00, -1, 5'd0, 8'h00, -1);
    endtask

    initial begin
        test_reset();
        test_full_init();
        test_full_pattern();
        test_invalid();
        test_single();
        test_collision();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
